pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter: DATA_W, 32, payload width (operands, PC, immediate, register indices).
REQ-002 SHALL have parameter: CTRL_W, 8, control-bit width (RegWrite/MemRead/MemWrite/Branch/ALUop...).
REQ-003 SHALL have parameter: CNT_W, 16, stall-counter width.
REQ-004 SHALL have port: clk  in  1  rising-edge clock.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: flush  in  1  kill all held entries (branch mispredict).
REQ-007 SHALL have port: in_valid  in  1  upstream entry valid.
REQ-008 SHALL have port: in_ready  out  1  stage can accept.
REQ-009 SHALL have port: in_ctrl  in  CTRL_W  upstream control bits.
REQ-010 SHALL have port: in_data  in  DATA_W  upstream payload.
REQ-011 SHALL have port: out_valid  out  1  entry presented downstream.
REQ-012 SHALL have port: out_ready  in  1  downstream accepts.
REQ-013 SHALL have port: out_ctrl  out  CTRL_W  control bits; all-zero whenever out_valid=0.
REQ-014 SHALL have port: out_data  out  DATA_W  payload.
REQ-015 SHALL have port: stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 SHALL transfer in on cycles with in_valid and in_ready both 1; transfer out on cycles with out_valid and out_ready both 1.
REQ-017 SHALL have main-register states EMPTY and FULL; EMPTY->FULL on in-transfer; FULL->EMPTY on out-transfer without in-transfer; FULL->FULL, with new entry loaded, on simultaneous in-transfer and out-transfer.
REQ-018 SHALL have a latency of exactly 1 cycle: an entry accepted at edge N is presented at out_* after edge N, with in_ready 1.
REQ-019 SHALL keep out_ctrl and out_data stable while out_valid=1 and out_ready=0.
REQ-020 SHALL force the stored ctrl to zero when entering EMPTY (bubble); out_data SHALL hold its last value.
REQ-021 SHALL, on flush=1, at that edge clear all entries to EMPTY, zero the stored ctrl, and ignore in_valid; in_ready is don't-care for that cycle.
REQ-022 SHALL treat flush and an out-transfer in the same cycle as a completed transfer; the downstream sees the entry and the stage still empties.
REQ-023 SHALL increment stall_cnt by 1 per stalled cycle, saturate at 2^CNT_W-1, and leave it unchanged by flush.
REQ-024 SHALL have no combinational path from in_* to out_*.

Reset
REQ-025 SHALL, on reset at a rising edge, set: state EMPTY, skid empty, out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
REQ-026 SHALL give reset priority over flush and all handshakes, including mid-stall; the held entry is discarded.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset is deasserted.

Configuration
REQ-028 SHALL provide the macro PIPE_STAGE_SKID_EN.
REQ-029 SHALL, with PIPE_STAGE_SKID_EN defined:
  - add a one-entry skid register and state FULL_SKID;
  - in_ready = registered (skid empty), with no combinational path from out_ready to in_ready;
  - an in-transfer during FULL with out_ready=0 goes to FULL_SKID;
  - from FULL_SKID, an out-transfer moves the skid entry to main and returns to FULL;
  - order SHALL be preserved.
REQ-030 SHALL, without PIPE_STAGE_SKID_EN, have a single entry, with in_ready = (state==EMPTY) | out_ready, combinational.

Verification
REQ-031 SHALL cover: reset, then in_valid=1, ctrl=0x5A, data=0x00001234, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x5A, out_data=0x00001234.
REQ-032 SHALL cover: entry held, out_ready=0 for 5 cycles -> out_* stable, stall_cnt=5; out_ready=1 -> transfer, state EMPTY, out_ctrl=0x00.
REQ-033 SHALL cover: flush=1 while FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0x00, and the input is not captured.
REQ-034 SHALL cover (SKID_EN): entries A=0x1, B=0x2 back-to-back with out_ready=0 -> in_ready=0 after B; out_ready=1 -> A then B on consecutive cycles.
REQ-035 SHALL cover: CNT_W=4, 20 stall cycles -> stall_cnt=15, held.
REQ-036 SHALL cover: reset asserted mid-stall with stall_cnt=7 -> next cycle out_valid=0, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   One pipeline stage register with valid/ready handshakes on both sides. It
//   carries a control field and a payload field. The stage is emptied on flush
//   (branch mispredict), inserts a zero-control bubble whenever it is empty,
//   and keeps a saturating count of downstream stall cycles.
//
//   Build option (macro PIPE_STAGE_SKID_EN):
//     undefined : single entry; in_ready = (state==EMPTY) | out_ready, which
//                 is combinational from out_ready.
//     defined   : adds a one-entry skid register and state FULL_SKID. in_ready
//                 is registered (skid empty), so there is no combinational
//                 path from out_ready to in_ready.
//
// Parameters
//   DATA_W  payload width
//   CTRL_W  control-bit width
//   CNT_W   stall-counter width
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   flush      in   drop every held entry; in_valid is ignored that cycle
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept
//   in_ctrl    in   upstream control bits
//   in_data    in   upstream payload
//   out_valid  out  entry presented downstream
//   out_ready  in   downstream accepts
//   out_ctrl   out  control bits, all-zero whenever out_valid=0
//   out_data   out  payload, holds its last value while empty
//   stall_cnt  out  saturating count of cycles with out_valid=1, out_ready=0
//
// States
//   EMPTY     | nothing held, out_valid=0
//   FULL      | main register holds the entry presented downstream
//   FULL_SKID | main and skid both hold entries (skid build only)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_FULL_SKID = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CNT_W-1:0]  stall_q;

  logic in_xfer;
  logic out_xfer;
  logic stalled;

  // datapath controls decoded from the FSM
  logic main_load_in;
  logic main_bubble;

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              ready_q;
  logic              main_load_skid;
  logic              skid_load;
`endif

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign out_valid = (state_q != ST_EMPTY);
  assign out_xfer  = out_valid & out_ready;
  assign stalled   = out_valid & ~out_ready;

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready = ready_q;
`else
  assign in_ready = (state_q == ST_EMPTY) | out_ready;
`endif

  // flush swallows the upstream side of the handshake; the downstream side
  // still completes normally if out_ready is high.
  assign in_xfer = in_valid & in_ready & ~flush;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) state_d = ST_FULL;
        end
        ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (in_xfer && !out_ready) begin
            state_d = ST_FULL_SKID;
          end else if (!in_xfer && out_ready) begin
            state_d = ST_EMPTY;
          end
`else
          if (out_xfer && !in_xfer) state_d = ST_EMPTY;
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL_SKID: begin
          // in_ready is low here, so only the drain side can move
          if (out_ready) state_d = ST_FULL;
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (datapath load / bubble controls)
  // ---------------------------------------------------------------------------
  always_comb begin
    main_load_in = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
`endif
    if (!flush) begin
      case (state_q)
        ST_EMPTY: begin
          main_load_in = in_xfer;
        end
        ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          main_load_in = in_xfer & out_ready;
          skid_load    = in_xfer & ~out_ready;
`else
          main_load_in = in_xfer;
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL_SKID: begin
          main_load_skid = out_ready;
        end
`endif
        default: main_load_in = 1'b0;
      endcase
    end
    // Landing in EMPTY (drain, flush, or idle) keeps a zero-control bubble.
    main_bubble = (state_d == ST_EMPTY);
  end

  // ---------------------------------------------------------------------------
  // Main register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (main_bubble) begin
      main_ctrl <= '0;
    end else if (main_load_in) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
`ifdef PIPE_STAGE_SKID_EN
    end else if (main_load_skid) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
`endif
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // ---------------------------------------------------------------------------
  // Skid register and registered in_ready
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      skid_ctrl <= '0;
    end else if (skid_load) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

  // in_ready is simply "skid will be empty next cycle", derived from the
  // next state so it never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d != ST_FULL_SKID);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stall counter (saturating, unaffected by flush)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stalled && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed plus short random traffic against pipe_stage_reg. A queue holds
//   every accepted entry in order; the head of the queue is what the stage
//   must present whenever it is valid. An occupancy count predicts out_valid
//   and in_ready, and two saturating counters predict stall_cnt for the
//   default instance and a CNT_W=4 instance sharing the same inputs.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [15:0] stall_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [7:0]  out_ctrl4;
  logic [31:0] out_data4;
  logic [3:0]  stall_cnt4;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl4),
    .out_data  (out_data4),
    .stall_cnt (stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [39:0] sb[$];
  int          m_cnt    = 0;
  int          m_stall  = 0;
  int          m_stall4 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the presented outputs against the
  // model, advance the model, then step through the clock edge.
  task automatic step(input logic iv, input logic [7:0] ic, input logic [31:0] id,
                      input logic ordy, input logic fl, input logic rs);
    logic        exp_ov;
    logic        exp_ir;
    logic        ix;
    logic        ox;
    logic [39:0] front;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    #1;
    exp_ov = (m_cnt > 0);
`ifdef PIPE_STAGE_SKID_EN
    exp_ir = (m_cnt < 2);
`else
    exp_ir = (m_cnt == 0) || ordy;
`endif
    if (!rs) begin
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
      if (!fl) check("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
      if (exp_ov && sb.size() > 0) begin
        front = sb[0];
        check("out_ctrl", {56'd0, out_ctrl}, {56'd0, front[39:32]});
        check("out_data", {32'd0, out_data}, {32'd0, front[31:0]});
      end else begin
        check("out_ctrl_bubble", {56'd0, out_ctrl}, 64'd0);
      end
      check("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
      check("stall_cnt4", {60'd0, stall_cnt4}, 64'(m_stall4));
    end
    ix = iv && exp_ir && !fl && !rs;
    ox = exp_ov && ordy && !rs;
    if (rs) begin
      m_cnt    = 0;
      m_stall  = 0;
      m_stall4 = 0;
      sb.delete();
    end else begin
      if (exp_ov && !ordy) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (ox && sb.size() > 0) void'(sb.pop_front());
      if (fl) begin
        sb.delete();
        m_cnt = 0;
      end else begin
        if (ix) sb.push_back({ic, id});
        m_cnt = m_cnt + int'(ix) - int'(ox);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = 8'h00;
    in_data   = 32'h0;
    out_ready = 1'b0;
    @(negedge clk);

    // reset state and in_ready right after reset release
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_ctrl",  {56'd0, out_ctrl}, 64'd0);
    check("rst_out_data",  {32'd0, out_data}, 64'd0);
    check("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready}, 64'd1);

    // single entry, one-cycle latency
    step(1'b1, 8'h5A, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    check("lat_out_valid", {63'd0, out_valid}, 64'd1);
    check("lat_out_ctrl",  {56'd0, out_ctrl}, 64'h5A);
    check("lat_out_data",  {32'd0, out_data}, 64'h1234);

    // simultaneous in/out transfer, then a 5-cycle stall and a drain
    step(1'b1, 8'hC3, 32'h0000_BEEF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    check("stall5_cnt",  {48'd0, stall_cnt}, 64'd5);
    check("stall5_ctrl", {56'd0, out_ctrl}, 64'hC3);
    check("stall5_data", {32'd0, out_data}, 64'hBEEF);
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
    check("drain_out_valid", {63'd0, out_valid}, 64'd0);
    check("drain_out_ctrl",  {56'd0, out_ctrl}, 64'd0);
    check("drain_data_hold", {32'd0, out_data}, 64'hBEEF);

    // flush while FULL with in_valid=1; the held entry still leaves downstream
    step(1'b1, 8'h11, 32'h0000_1111, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h22, 32'h0000_2222, 1'b1, 1'b1, 1'b0);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_out_ctrl",  {56'd0, out_ctrl}, 64'd0);
    check("flush_data_hold", {32'd0, out_data}, 64'h1111);
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);

    // back-to-back A, B against a stalled downstream
    step(1'b1, 8'h01, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    check("b2b_in_ready", {63'd0, in_ready}, 64'd0);
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    check("b2b_b_valid", {63'd0, out_valid}, 64'd1);
    check("b2b_b_data",  {32'd0, out_data}, 64'h2);
`else
    check("b2b_empty", {63'd0, out_valid}, 64'd0);
`endif
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);

    // saturation of the 4-bit counter
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h77, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    check("sat_cnt4",  {60'd0, stall_cnt4}, 64'd15);
    check("sat_cnt16", {48'd0, stall_cnt}, 64'd20);
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    check("sat_cnt4_held", {60'd0, stall_cnt4}, 64'd15);

    // reset in the middle of a stall
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h3C, 32'h0000_3C3C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_cnt", {48'd0, stall_cnt}, 64'd7);
    step(1'b1, 8'h99, 32'h0000_9999, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    check("midrst_in_ready",  {63'd0, in_ready}, 64'd1);
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);

    // random traffic, then drain
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
           ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
    check("final_empty", {63'd0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
